counter_checker: RTL and testbench

- Synthesizable consumer of the up/down counter bus (rst, en, up_dn, counter).
- Samples the DUT's control inputs and count every cycle, predicts the next count, and flags mismatches in hardware.
- Sits beside any counter instance. Gives silicon/FPGA builds the same guarantee the bench assertion gives in simulation, in both count directions.
- Provides a sticky flag, a saturating error count and first-error capture registers.

---
 rtl/counter_checker.sv | 105 ++++++++++
 tb/tb_counter_checker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/counter_checker.sv
// counter_checker: hardware monitor for an up/down counter bus; predicts each next count and flags mismatches.
// Optional macro COUNTER_CHK_LOAD_EN adds load/load_val ports for loadable counters.
`default_nettype none
module counter_checker #(
  parameter int          N         = 8,
  parameter int          CNT_W     = 8,
  parameter logic [N-1:0] RST_VAL  = '0,
  parameter int          CHECK_RST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic [N-1:0]     counter,
`ifdef COUNTER_CHK_LOAD_EN
  input  logic             load,
  input  logic [N-1:0]     load_val,
`endif
  input  logic             clr,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [N-1:0]     first_exp,
  output logic [N-1:0]     first_obs
);

  typedef enum logic [0:0] {SYNC = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [N-1:0]     exp_q, exp_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [N-1:0]     first_exp_q, first_exp_d;
  logic [N-1:0]     first_obs_q, first_obs_d;

  logic [N-1:0]     pred;
  logic [N-1:0]     cmp_exp;
  logic             mismatch;

  always_comb begin
    pred = counter;
    if (en) begin
      pred = up_dn ? (counter - N'(1)) : (counter + N'(1));
    end
`ifdef COUNTER_CHK_LOAD_EN
    if (load) begin
      pred = load_val;
    end
`endif

    // The first sample after reset is checked against RST_VAL, later ones against the prediction.
    cmp_exp  = (state_q == SYNC) ? RST_VAL : exp_q;
    mismatch = (counter != cmp_exp) && ((state_q == TRACK) || (CHECK_RST != 0));

    state_d     = TRACK;
    exp_d       = pred;
    err_pulse_d = mismatch;

    err_sticky_d = clr ? 1'b0 : err_sticky_q;
    err_count_d  = clr ? '0 : err_count_q;
    first_exp_d  = clr ? '0 : first_exp_q;
    first_obs_d  = clr ? '0 : first_obs_q;

    // A mismatch on the same edge as clr wins: it counts as the first error after the clear.
    if (mismatch) begin
      err_sticky_d = 1'b1;
      err_count_d  = (err_count_d == CNT_MAX) ? CNT_MAX : (err_count_d + CNT_W'(1));
      if (!err_sticky_q || clr) begin
        first_exp_d = cmp_exp;
        first_obs_d = counter;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SYNC;
      exp_q        <= '0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      first_exp_q  <= '0;
      first_obs_q  <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      first_exp_q  <= first_exp_d;
      first_obs_q  <= first_obs_d;
    end
  end

  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
  assign first_exp  = first_exp_q;
  assign first_obs  = first_obs_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_checker.sv
// tb_counter_checker: directed stimulus, arithmetic reference model and per-cycle output comparison.
`default_nettype none
module tb_counter_checker;

  localparam int N       = 8;
  localparam int CNT_W   = 8;
  localparam int RST_VAL = 0;
  localparam bit CHK_RST = 1'b1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             up_dn = 1'b0;
  logic [N-1:0]     counter = '0;
  logic             clr = 1'b0;
  logic             err_pulse;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;
  logic [N-1:0]     first_exp;
  logic [N-1:0]     first_obs;

  int checks = 0;
  int errors = 0;

  counter_checker #(.N(N), .CNT_W(CNT_W), .RST_VAL(N'(RST_VAL)), .CHECK_RST(1)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .counter(counter),
`ifdef COUNTER_CHK_LOAD_EN
    .load(1'b0), .load_val('0),
`endif
    .clr(clr), .err_pulse(err_pulse), .err_sticky(err_sticky), .err_count(err_count),
    .first_exp(first_exp), .first_obs(first_obs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers the previous sample and derives the expected count arithmetically.
  bit m_valid;
  int m_pred, m_pulse, m_sticky, m_count, m_fexp, m_fobs;
  int t_exp, t_sticky, t_count, t_fexp, t_fobs;
  bit t_bad;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_pred <= 0; m_pulse <= 0; m_sticky <= 0;
      m_count <= 0; m_fexp <= 0; m_fobs <= 0;
    end else begin
      t_exp    = m_valid ? m_pred : RST_VAL;
      t_bad    = (m_valid || CHK_RST) && (int'(counter) != t_exp);
      t_sticky = clr ? 0 : m_sticky;
      t_count  = clr ? 0 : m_count;
      t_fexp   = clr ? 0 : m_fexp;
      t_fobs   = clr ? 0 : m_fobs;
      if (t_bad) begin
        if (t_sticky == 0) begin
          t_fexp = t_exp;
          t_fobs = int'(counter);
        end
        t_sticky = 1;
        t_count  = (t_count < (1 << CNT_W) - 1) ? t_count + 1 : (1 << CNT_W) - 1;
      end
      m_pulse  <= t_bad ? 1 : 0;
      m_sticky <= t_sticky;
      m_count  <= t_count;
      m_fexp   <= t_fexp;
      m_fobs   <= t_fobs;
      m_pred   <= (int'(counter) + (en ? (up_dn ? (1 << N) - 1 : 1) : 0)) % (1 << N);
      m_valid  <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("pulse", int'(err_pulse), m_pulse);
      chk("sticky", int'(err_sticky), m_sticky);
      chk("count", int'(err_count), m_count);
      chk("first_exp", int'(first_exp), m_fexp);
      chk("first_obs", int'(first_obs), m_fobs);
    end
  end

  // Called at a falling edge; the following rising edge samples these inputs.
  task automatic step(input logic e, input logic d, input int c, input logic cl);
    en = e; up_dn = d; counter = N'(c); clr = cl;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", int'(err_count), 0);
    chk("rst_sticky", int'(err_sticky), 0);
    chk("rst_pulse", int'(err_pulse), 0);
    rst = 1'b0;

    for (int i = 0; i <= 10; i++) step(1'b1, 1'b0, i, 1'b0);
    chk("upcount_count", int'(err_count), 0);

    do_reset();
    step(1, 1, 0, 0);   step(1, 1, 255, 0); step(1, 0, 254, 0); step(1, 0, 255, 0);
    step(1, 0, 0, 0);   step(1, 1, 1, 0);   step(1, 1, 0, 0);   step(1, 1, 255, 0);
    step(0, 0, 254, 0); step(0, 0, 254, 0);
    chk("wrap_count", int'(err_count), 0);
    chk("wrap_sticky", int'(err_sticky), 0);

    do_reset();
    for (int i = 0; i <= 5; i++) step(1'b1, 1'b0, i, 1'b0);
    step(1, 0, 7, 0);
    chk("glitch_pulse", int'(err_pulse), 1);
    chk("glitch_count", int'(err_count), 1);
    chk("glitch_sticky", int'(err_sticky), 1);
    chk("glitch_fexp", int'(first_exp), 6);
    chk("glitch_fobs", int'(first_obs), 7);
    step(1, 0, 8, 0);
    chk("resync_pulse", int'(err_pulse), 0);
    chk("resync_count", int'(err_count), 1);

    do_reset();
    for (int i = 0; i <= 3; i++) step(1'b1, 1'b0, i, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 3, 1'b0);
    chk("stuck_count", int'(err_count), 255);
    chk("stuck_fexp", int'(first_exp), 4);
    chk("stuck_fobs", int'(first_obs), 3);

    // Asynchronous reset mid-cycle must clear outputs without a clock edge.
    #2 rst = 1'b1;
    #1;
    chk("async_count", int'(err_count), 0);
    chk("async_sticky", int'(err_sticky), 0);
    chk("async_fexp", int'(first_exp), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    step(1, 0, 9, 0);
    chk("rstval_pulse", int'(err_pulse), 1);
    chk("rstval_fexp", int'(first_exp), 0);
    chk("rstval_fobs", int'(first_obs), 9);
    chk("rstval_count", int'(err_count), 1);
    step(1, 0, 20, 1);
    chk("clrmis_count", int'(err_count), 1);
    chk("clrmis_sticky", int'(err_sticky), 1);
    chk("clrmis_fexp", int'(first_exp), 10);
    chk("clrmis_fobs", int'(first_obs), 20);
    step(1, 0, 21, 1);
    chk("clr_count", int'(err_count), 0);
    chk("clr_sticky", int'(err_sticky), 0);
    chk("clr_fobs", int'(first_obs), 0);
    step(1, 0, 22, 0);
    chk("post_clr_pulse", int'(err_pulse), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
